// File: rtl/pmod_als_pkg.sv
// Shared types and constants for the PmodALS emulator.
package pmod_als_pkg;

  localparam int FRAME_BITS_DEFAULT = 16;
  localparam int LEAD_ZEROS         = 3;
  localparam int TRAIL_ZEROS        = 5;
  localparam int SAMPLE_W           = 8;
  localparam int WORD_W             = LEAD_ZEROS + SAMPLE_W + TRAIL_ZEROS;
  localparam int CNT_W              = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } als_state_e;

  // Builds the outgoing word: leading zeros, sample MSB first, trailing zeros.
  function automatic logic [WORD_W-1:0] frame_word(input logic [SAMPLE_W-1:0] sample);
    return {{LEAD_ZEROS{1'b0}}, sample, {TRAIL_ZEROS{1'b0}}};
  endfunction

endpackage

// File: rtl/pmod_als_emulator_sync_edge.sv
// Multi-flop synchronizer for an asynchronous, idle-high input, followed by
// one edge-detect register that yields single-cycle rise/fall pulses.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  // Edges are suppressed until the chain has been refilled with real input
  // after reset, so a line that was already low is not mistaken for a fall.
  localparam int FILL_MAX = SYNC_STAGES + 1;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);

  logic [SYNC_STAGES-1:0] stage_q;
  logic [SYNC_STAGES-1:0] stage_d;
  logic                   prev_q;
  logic [FILL_W-1:0]      fill_q;
  logic                   settled;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_d[gi] = din;
      end else begin : g_next
        assign stage_d[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  assign settled = (fill_q == FILL_W'(FILL_MAX));
  assign rise    = settled &  stage_q[SYNC_STAGES-1] & ~prev_q;
  assign fall    = settled & ~stage_q[SYNC_STAGES-1] &  prev_q;

  // Synchronizer chain, edge-detect register and post-reset settle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '1;
      prev_q  <= 1'b1;
      fill_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= stage_q[SYNC_STAGES-1];
      if (!settled) begin
        fill_q <= fill_q + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/pmod_als_emulator.sv
// Emulates the PmodALS SPI light sensor: on chip-select fall the light sample
// is latched into a 16-bit word and shifted out MSB first on SCLK falls.
module pmod_als_emulator
  import pmod_als_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  input  logic                cs,
  input  logic [SAMPLE_W-1:0] light,
  output logic                sdo,
  output logic                sdo_en,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_err
);

  logic scl_rise, scl_fall;
  logic cs_rise, cs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (scl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (cs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  als_state_e        state_q;
  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              sdo_en_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [WORD_W-1:0] latch_word;

  assign latch_word = frame_word(light);

  // Saturating rising-edge counter value for this cycle.
  assign cnt_d = (cnt_q == CNT_W'(FRAME_BITS)) ? cnt_q : cnt_q + CNT_W'(1);

  // The word MSB is the sdo line; the word is cleared whenever not shifting,
  // which keeps sdo low outside SHIFT without a separate output register.
  assign sdo        = word_q[WORD_W-1];
  assign sdo_en     = sdo_en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

  // Frame FSM: latch on cs fall, shift on scl falls, count scl rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      cnt_q    <= '0;
      sdo_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          word_q <= '0;
          // Any scl edge coincident with the cs fall is deliberately dropped.
          if (cs_fall) begin
            word_q   <= latch_word;
            cnt_q    <= '0;
            state_q  <= ST_SHIFT;
            sdo_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            err_q    <= (cnt_q < CNT_W'(FRAME_BITS));
            word_q   <= '0;
            state_q  <= ST_IDLE;
            sdo_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (scl_rise) begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(FRAME_BITS)) begin
              done_q  <= 1'b1;
              word_q  <= '0;
              state_q <= ST_HOLD;
              busy_q  <= 1'b0;
            end
          end else if (scl_fall && (cnt_q != '0)) begin
            // The first fall after cs is the idle-high lead-in; the MSB is
            // already on the line for the master's first rising-edge sample.
            word_q <= {word_q[WORD_W-2:0], 1'b0};
          end
        end
        ST_HOLD: begin
          word_q <= '0;
          if (cs_rise) begin
            state_q  <= ST_IDLE;
            sdo_en_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          word_q   <= '0;
          sdo_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_als_emulator.sv
// Bench for pmod_als_emulator: acts as an SPI master sampling on scl rise.
module tb_pmod_als_emulator;

  localparam int SYNC = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl   = 1'b1;
  logic       cs    = 1'b1;
  logic [7:0] light = 8'h00;
  logic       sdo, sdo_en, busy, frame_done, frame_err;

  pmod_als_emulator #(.SYNC_STAGES(SYNC), .FRAME_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .cs        (cs),
    .light     (light),
    .sdo       (sdo),
    .sdo_en    (sdo_en),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  typedef struct {
    logic [7:0]  light;
    logic [7:0]  light_mid;
    int          mid_at;
    int          periods;
    int          abort_at;
    logic [15:0] exp_cap;
    int          exp_done;
    int          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the frame is 3 zero bits, the latched sample, then 5 zero bits.
  function automatic logic [15:0] model_word(input logic [7:0] s);
    return 16'(s) * 16'd32;
  endfunction

  // One master transaction; scl period 100 ns, cs high for 2 periods after.
  task automatic run_frame(input vec_t v, input string tag);
    logic [31:0] samp;
    logic [15:0] got, mask;
    int ns, nchk, d0, e0;
    samp = '0;
    ns = 0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk); #2;
    light = v.light;
    cs = 1'b0;
    #50;
    for (int p = 1; p <= v.periods; p++) begin
      scl = 1'b0;
      if (p == v.mid_at) light = v.light_mid;
      #50;
      scl = 1'b1;
      samp[p-1] = sdo;
      ns = p;
      if (p == 4) begin
        check({tag, " busy_mid"}, busy, 1'b1);
        check({tag, " sdo_en_mid"}, sdo_en, 1'b1);
      end
      if (p == 17) begin
        check({tag, " busy_hold"}, busy, 1'b0);
        check({tag, " sdo_en_hold"}, sdo_en, 1'b1);
      end
      #50;
      if (p == v.abort_at) break;
    end
    cs = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    check({tag, " sdo_en_off"}, sdo_en, 1'b0);
    check({tag, " sdo_off"}, sdo, 1'b0);
    #199;
    nchk = (v.abort_at != 0) ? v.abort_at : 16;
    got = '0;
    for (int i = 0; i < nchk; i++) got[15-i] = samp[i];
    mask = 16'hFFFF << (16 - nchk);
    check({tag, " capture"}, got, v.exp_cap & mask);
    if (ns > 16) check({tag, " tail_zero"}, samp >> 16, 32'd0);
    check({tag, " done_pulses"}, done_cnt - d0, v.exp_done);
    check({tag, " err_pulses"}, err_cnt - e0, v.exp_err);
    $display("frame %s light=%h periods=%0d abort=%0d capture=%h done=%0d err=%0d",
             tag, v.light, v.periods, v.abort_at, got, done_cnt - d0, err_cnt - e0);
  endtask

  vec_t vecs[6];
  vec_t rv;
  int d0, e0;

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 0, 16, 0, 16'h14A0, 1, 0};
    vecs[1] = '{8'hFF, 8'hFF, 0, 16, 0, 16'h1FE0, 1, 0};
    vecs[2] = '{8'h00, 8'h00, 0, 16, 0, 16'h0000, 1, 0};
    vecs[3] = '{8'h3C, 8'hC3, 8, 16, 0, 16'h0780, 1, 0};
    vecs[4] = '{8'h5A, 8'hFF, 0, 16, 8, 16'h0B40, 0, 1};
    vecs[5] = '{8'h81, 8'h00, 0, 20, 0, 16'h1020, 1, 0};

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst sdo", sdo, 1'b0);
    check("rst sdo_en", sdo_en, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst frame_done", frame_done, 1'b0);
    check("rst frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Reset released with cs already low must not start a frame
    cs = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("cs_low_after_rst busy", busy, 1'b0);
    check("cs_low_after_rst sdo_en", sdo_en, 1'b0);
    $display("seq reset-with-cs-low busy=%0b sdo_en=%0b", busy, sdo_en);
    cs = 1'b1;
    repeat (10) @(negedge clk);

    // Table vectors (0..2 back to back with 2 scl periods of cs high)
    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted at scl rise 5 mid-frame, released with cs high
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk); #2;
    light = 8'h55;
    cs = 1'b0;
    #50;
    for (int p = 1; p <= 5; p++) begin
      scl = 1'b0;
      #50;
      scl = 1'b1;
      if (p != 5) #50;
    end
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid err_pulses", err_cnt - e0, 0);
    check("rst_mid done_pulses", done_cnt - d0, 0);
    check("rst_mid sdo_en", sdo_en, 1'b0);
    $display("seq reset-mid-frame err=%0d done=%0d", err_cnt - e0, done_cnt - d0);
    rv = '{8'h81, 8'h81, 0, 16, 0, 16'h1020, 1, 0};
    run_frame(rv, "after_rst");

    // Randomized frames against the reference model
    for (int i = 0; i < 8; i++) begin
      rv.light     = 8'($urandom);
      rv.light_mid = 8'($urandom);
      rv.mid_at    = int'($urandom_range(1, 16));
      rv.periods   = int'($urandom_range(16, 20));
      rv.abort_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 15)) : 0;
      rv.exp_cap   = model_word(rv.light);
      rv.exp_done  = (rv.abort_at != 0) ? 0 : 1;
      rv.exp_err   = (rv.abort_at != 0) ? 1 : 0;
      run_frame(rv, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmod_als_emulator.md
PMOD_ALS_EMULATOR -- requirements
Module: pmod_als_emulator

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on scl and cs.
REQ-002 Parameter FRAME_BITS, default 16, SCLK periods per conversion frame.
REQ-003 clk  input  1  single system clock; all logic on rising edge; clk frequency at least 8x scl frequency.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 scl  input  1  SPI serial clock from master, asynchronous to clk, idle high.
REQ-006 cs  input  1  SPI chip select from master, active-low, asynchronous to clk.
REQ-007 light  input  8  emulated ambient-light sample.
REQ-008 sdo  output  1  serial data to master.
REQ-009 sdo_en  output  1  sdo drive enable; 0 means the top level tristates the pin.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 frame_done  output  1  one-clk pulse on completion of a full frame.
REQ-012 frame_err  output  1  one-clk pulse on a frame aborted early by cs rising.

Function
REQ-013 scl and cs SHALL each pass through SYNC_STAGES flops before use, followed by one edge-detect register.
REQ-014 The FSM SHALL have the states IDLE, SHIFT, and HOLD.
REQ-015 IDLE: on a synchronized cs falling edge, the block SHALL latch light into shift word {3'b000, light, 5'b00000}, set bit_cnt=0, and go to SHIFT in the same cycle.
REQ-016 In SHIFT, sdo SHALL present shift word bit 15 from the cycle after the cs fall is detected.
REQ-017 On each synchronized scl falling edge in SHIFT, the block SHALL shift the word left by one, fill with 0, and present the new MSB on sdo.
REQ-018 On each synchronized scl rising edge in SHIFT, bit_cnt SHALL increment, 5 bits wide, saturating at FRAME_BITS.
REQ-019 When bit_cnt reaches FRAME_BITS, the block SHALL pulse frame_done for one cycle and go to HOLD.
REQ-020 In HOLD, sdo SHALL be 0 regardless of further scl edges, and a cs rise SHALL return the FSM to IDLE.
REQ-021 In SHIFT, a cs rise with bit_cnt < FRAME_BITS SHALL pulse frame_err for one cycle and return the FSM to IDLE; frame_done SHALL stay 0.
REQ-022 sdo_en SHALL equal 1 exactly in SHIFT and HOLD; sdo SHALL be 0 whenever sdo_en is 0.
REQ-023 busy SHALL be 1 exactly in SHIFT.
REQ-024 Changes on light after the latch point SHALL NOT affect the current frame.
REQ-025 If the cs fall and the first scl edge are detected in the same clk, the cs fall SHALL be processed first and that scl edge ignored.
REQ-026 A cs fall while in HOLD SHALL be impossible by construction (cs is already low); a new frame SHALL require a cs rise and then a fall.

Reset
REQ-027 While rst_n=0 at a clk edge, the block SHALL reset: FSM to IDLE, shift word 0, bit_cnt 0, sdo 0, sdo_en 0, busy 0, frame_done 0, frame_err 0, synchronizer flops to 1 (idle-high scl and cs).
REQ-028 Reset during SHIFT SHALL abort the frame without a frame_err pulse.
REQ-029 After reset is released with cs already low, the block SHALL NOT start a frame until a cs fall is seen.

Structure
REQ-030 Package pmod_als_pkg SHALL hold the FSM state enum, FRAME_BITS default, LEAD_ZEROS=3, and TRAIL_ZEROS=5.
REQ-031 Sub-module sync_edge SHALL contain the SYNC_STAGES synchronizer plus rise/fall pulse outputs, and SHALL be instantiated for scl and for cs.

Verification
REQ-032 light=8'hA5, clk 100 MHz, scl 10 MHz, 16 scl periods: master sampling on scl rise SHALL capture 16'h14A0, with one frame_done pulse.
REQ-033 light=8'hFF then 8'h00, two back-to-back frames with cs high for 2 scl periods between them: captures SHALL be 16'h1FE0 then 16'h0000.
REQ-034 cs raised after 8 scl rises: frame_err SHALL pulse once, frame_done SHALL stay 0, sdo_en SHALL be 0 within SYNC_STAGES+2 clk.
REQ-035 light changed from 8'h3C to 8'hC3 mid-frame: capture SHALL be 16'h0780.
REQ-036 rst_n asserted at scl rise 5, then released with cs high, then a full frame with light=8'h81: no frame_err, then capture 16'h1020.
REQ-037 20 scl periods in one frame: first 16 bits SHALL be correct, sdo SHALL be 0 afterwards, and frame_done SHALL pulse once.
